// File: rtl/data_bus_arbiter.sv
// Two-master arbiter for the data-memory port: round-robin address phase, in-order owner FIFO for response routing.
// Define ARB_FIXED_PRIO_EN to make m0 (LSU) always win ties instead of round-robin.
module data_bus_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         m0_req_i,
  input  logic [ADDR_W-1:0]            m0_add_i,
  input  logic                         m0_we_i,
  input  logic [DATA_W/8-1:0]          m0_be_i,
  input  logic [DATA_W-1:0]            m0_wdata_i,
  output logic                         m0_gnt_o,
  output logic                         m0_rvalid_o,
  output logic [DATA_W-1:0]            m0_rdata_o,
  input  logic                         m1_req_i,
  input  logic [ADDR_W-1:0]            m1_add_i,
  input  logic                         m1_we_i,
  input  logic [DATA_W/8-1:0]          m1_be_i,
  input  logic [DATA_W-1:0]            m1_wdata_i,
  output logic                         m1_gnt_o,
  output logic                         m1_rvalid_o,
  output logic [DATA_W-1:0]            m1_rdata_o,
  output logic                         data_req_o,
  output logic [ADDR_W-1:0]            data_add_o,
  output logic                         data_we_o,
  output logic [DATA_W/8-1:0]          data_be_o,
  output logic [DATA_W-1:0]            data_wdata_o,
  input  logic                         data_gnt_in,
  input  logic                         data_rvalid,
  input  logic [DATA_W-1:0]            data_rdata_in,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
  output logic                         err_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] owner_q;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             lock, lock_sel, err_q;
  logic             sel, sel_req, tie_sel;
  logic             fifo_full, fifo_empty, push, pop, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef ARB_FIXED_PRIO_EN
  assign tie_sel = 1'b0;
`else
  logic rr_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rr_last <= 1'b1;
    else if (push) rr_last <= sel;
  end

  assign tie_sel = ~rr_last;
`endif

  assign fifo_full  = (count == CW'(DEPTH));
  assign fifo_empty = (count == '0);

  // A stalled request keeps its master selected until the memory accepts it.
  always_comb begin
    sel = 1'b0;
    if (lock)                       sel = lock_sel;
    else if (m0_req_i && m1_req_i)  sel = tie_sel;
    else if (m1_req_i)              sel = 1'b1;
  end

  always_comb begin
    sel_req      = sel ? m1_req_i   : m0_req_i;
    data_add_o   = sel ? m1_add_i   : m0_add_i;
    data_we_o    = sel ? m1_we_i    : m0_we_i;
    data_be_o    = sel ? m1_be_i    : m0_be_i;
    data_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
  end

  assign data_req_o = sel_req & ~fifo_full;
  assign push       = data_req_o & data_gnt_in;
  assign pop        = data_rvalid & ~fifo_empty;
  assign head       = owner_q[rd_ptr];

  assign m0_gnt_o    = push & ~sel;
  assign m1_gnt_o    = push & sel;
  assign m0_rvalid_o = pop & ~head;
  assign m1_rvalid_o = pop & head;
  assign m0_rdata_o  = data_rdata_in;
  assign m1_rdata_o  = data_rdata_in;

  assign outstanding_o = count;
  assign err_o         = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock     <= 1'b0;
      lock_sel <= 1'b0;
    end else if (push) begin
      lock     <= 1'b0;
    end else if (data_req_o) begin
      lock     <= 1'b1;
      lock_sel <= sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) begin
        owner_q[wr_ptr] <= sel;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (data_rvalid && fifo_empty) err_q <= 1'b1;
    end
  end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Shares the single data-memory port between two requesters: m0 = LSU, m1 = secondary master (debug/DMA).
- Uses req/gnt/rvalid handshakes on both the master side and the memory side.
- Arbitrates address phases round-robin and tracks outstanding transactions in an in-order owner FIFO.
- Steers each rvalid/rdata back to the master that issued the request; sits between the LSU and the data memory.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- DEPTH, 2, maximum outstanding transactions (owner FIFO depth, power of 2, ≥1)

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- mX_req_i  input  1  request, X∈{0,1}; held until mX_gnt_o
- mX_add_i  input  ADDR_W  address
- mX_we_i  input  1  1 = store, 0 = load
- mX_be_i  input  DATA_W/8  byte enables
- mX_wdata_i  input  DATA_W  store data
- mX_gnt_o  output  1  address phase accepted
- mX_rvalid_o  output  1  response valid for master X
- mX_rdata_o  output  DATA_W  response data, valid when mX_rvalid_o
- data_req_o  output  1  request to memory
- data_add_o  output  ADDR_W  memory address
- data_we_o  output  1  memory write enable
- data_be_o  output  DATA_W/8  memory byte enables
- data_wdata_o  output  DATA_W  memory write data
- data_gnt_in  input  1  memory grant
- data_rvalid  input  1  memory response valid, strictly in order
- data_rdata_in  input  DATA_W  memory response data
- outstanding_o  output  $clog2(DEPTH+1)  current FIFO occupancy
- err_o  output  1  sticky: rvalid received with FIFO empty

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty, outstanding_o=0, err_o=0.
  - Lock cleared; rr_last=1, so m0 wins the first tie.
  - All gnt/rvalid/req outputs 0.
- Selection:
  - If lock is set, sel = locked master.
  - Otherwise, one requester: that master.
  - Otherwise, both requesting: the master not equal to rr_last (fixed-priority under macro).
- Forwarding (combinational):
  - data_req_o = sel_req & ~fifo_full.
  - data_add_o/we/be/wdata = selected master's fields; when no request, m0 fields.
- Grant:
  - mX_gnt_o = data_gnt_in & data_req_o & (sel==X).
  - Zero-cycle grant path allowed; never grant the unselected master.
- Lock:
  - Set when data_req_o=1 and data_gnt_in=0; holds sel so a presented request cannot be switched.
  - Cleared on the accepting handshake.
- rr_last: updated to sel on each handshake (data_req_o & data_gnt_in).
- FIFO:
  - Push owner id (sel) on handshake.
  - Pop on data_rvalid when not empty.
  - Push and pop in the same cycle: occupancy unchanged.
  - Full: data_req_o forced 0 even if a pop occurs this cycle (no bypass); lock is not set while full.
- Response routing:
  - mX_rvalid_o = data_rvalid & ~fifo_empty & (head==X).
  - Both mX_rdata_o = data_rdata_in (unqualified).
  - Latency: memory rvalid → master rvalid, 0 cycles.
- Boundary conditions:
  - data_rvalid with FIFO empty: no rvalid to either master, err_o set (sticky until reset).
  - Reset mid-operation: FIFO and lock cleared immediately; late rvalids from pre-reset requests count as spurious (err_o).
  - Master deasserting req before gnt is a protocol violation; behaviour undefined, not checked.
  - DEPTH=1: strictly one outstanding; next request forwarded the cycle after the pop.

Optional Feature:
- ARB_FIXED_PRIO_EN defined: rr_last ignored; m0 (LSU) always wins ties; lock rules unchanged.
- Undefined: round-robin as above.

Test Plan:
- m0 load 0x100, gnt same cycle, rvalid 2 cycles later with rdata 0xDEADBEEF → m0_gnt_o=1 at cycle 0, m0_rvalid_o=1 with m0_rdata_o=0xDEADBEEF at cycle 2, m1_rvalid_o=0, outstanding_o back to 0.
- m0 and m1 requesting continuously, gnt=1 every cycle, rvalid 1 cycle later → grants alternate m0,m1,m0,m1; rvalids routed in the same order; with ARB_FIXED_PRIO_EN all grants go to m0.
- m1 presented, gnt held 0 for 3 cycles while m0 asserts → data_add_o stays on m1 address, m1 granted in cycle 3, m0 granted next.
- DEPTH=2, gnt=1, no rvalid → two handshakes, outstanding_o=2, data_req_o=0 in cycle 2; rvalid in cycle 3 → req reforwarded in cycle 4.
- data_rvalid pulse with FIFO empty → no master rvalid, err_o=1 and stays 1; rst_n low → err_o=0.
- Reset asserted with 2 outstanding → outstanding_o=0 asynchronously; subsequent rvalid sets err_o, no master rvalid.
